// File: rtl/cart_loader_if.sv
// SDRAM write-port bundle between the cartridge loader (master) and the
// memory controller (slave): one word per request, one-cycle ack.
interface cart_loader_if;
   logic        mem_req;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_be;
   logic        mem_ack;

   modport master (output mem_req, output mem_addr, output mem_din,
                   output mem_be, input mem_ack);
   modport slave  (input mem_req, input mem_addr, input mem_din,
                   input mem_be, output mem_ack);
endinterface

// File: rtl/cart_loader.sv
// Packs cartridge download bytes into 16-bit words, buffers them in a small
// FIFO and writes them to SDRAM; also tracks cartridge presence and size.
module cart_loader #(
   parameter logic [23:0] BASE_ADDR  = 24'h040000,
   parameter int          MAX_BYTES  = 65536,
   parameter int          FIFO_DEPTH = 4,
   parameter int          CART_BIT   = 0
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_download,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   input  logic          eject,
   cart_loader_if.master mem,
   output logic          cart_present,
   output logic [16:0]   cart_size,
   output logic          busy,
   output logic          overflow
);
   localparam int          PW       = $clog2(FIFO_DEPTH);
   localparam logic [24:0] MAX_ADDR = 25'(MAX_BYTES);
   localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

   typedef struct packed {
      logic [15:0] w;
      logic [15:0] data;
      logic [1:0]  be;
   } entry_t;

   state_t      state_q, state_d;
   logic        cart_dl, cart_dl_q;
   logic        held_vld_q, held_vld_d;
   logic [7:0]  held_byte_q, held_byte_d;
   logic [15:0] held_w_q, held_w_d;
   logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   entry_t      fifo_q [FIFO_DEPTH];
   entry_t      fifo_d [FIFO_DEPTH];
   logic        mem_req_q, mem_req_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_din_q, mem_din_d;
   logic [1:0]  mem_be_q, mem_be_d;
   logic        present_q, present_d;
   logic [16:0] size_q, size_d;
   logic        ovf_q, ovf_d;

   logic        fifo_empty, fifo_full, push, pop, in_range;
   entry_t      push_entry, head;
   logic [15:0] byte_w;
   logic [16:0] byte_end;
   logic        unused_idx;

   assign cart_dl    = ioctl_download & ioctl_index[CART_BIT];
   assign unused_idx = ^ioctl_index;
   assign in_range   = ioctl_addr < MAX_ADDR;
   assign byte_w     = ioctl_addr[16:1];
   assign byte_end   = ioctl_addr[16:0] + 17'd1;
   assign fifo_empty = wr_ptr_q == rd_ptr_q;
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign head       = fifo_q[rd_ptr_q[PW-1:0]];
   // A new request can only be issued from a cycle where mem_req is low,
   // which guarantees one idle cycle between back-to-back writes.
   assign pop        = !mem_req_q && !fifo_empty;

   always_comb begin
      state_d     = state_q;
      held_vld_d  = held_vld_q;
      held_byte_d = held_byte_q;
      held_w_d    = held_w_q;
      present_d   = present_q;
      size_d      = size_q;
      ovf_d       = ovf_q;
      push        = 1'b0;
      push_entry  = '0;

      case (state_q)
         IDLE: begin
            if (cart_dl && !cart_dl_q) begin
               present_d  = 1'b0;
               size_d     = '0;
               ovf_d      = 1'b0;
               held_vld_d = 1'b0;
               state_d    = LOAD;
            end else if (eject) begin
               present_d = 1'b0;
            end
         end
         LOAD: begin
            if (!cart_dl) begin
               if (held_vld_q) begin
                  push       = 1'b1;
                  push_entry = '{w: held_w_q, data: {8'h00, held_byte_q}, be: 2'b01};
               end
               held_vld_d = 1'b0;
               state_d    = DRAIN;
            end else if (ioctl_wr) begin
               if (!in_range) begin
                  ovf_d = 1'b1;
               end else if (!ioctl_addr[0]) begin
                  if (held_vld_q) begin
                     push       = 1'b1;
                     push_entry = '{w: held_w_q, data: {8'h00, held_byte_q}, be: 2'b01};
                  end
                  held_vld_d  = 1'b1;
                  held_byte_d = ioctl_dout;
                  held_w_d    = byte_w;
                  if (byte_end > size_q) size_d = byte_end;
               end else if (held_vld_q && held_w_q == byte_w) begin
                  push       = 1'b1;
                  push_entry = '{w: byte_w, data: {ioctl_dout, held_byte_q}, be: 2'b11};
                  held_vld_d = 1'b0;
                  if (byte_end > size_q) size_d = byte_end;
               end else if (held_vld_q) begin
                  // Out-of-order high byte: keep the orphan low byte, drop this one.
                  push       = 1'b1;
                  push_entry = '{w: held_w_q, data: {8'h00, held_byte_q}, be: 2'b01};
                  held_vld_d = 1'b0;
                  ovf_d      = 1'b1;
               end else begin
                  push       = 1'b1;
                  push_entry = '{w: byte_w, data: {ioctl_dout, 8'h00}, be: 2'b10};
                  if (byte_end > size_q) size_d = byte_end;
               end
            end
         end
         DRAIN: begin
            if (fifo_empty && !mem_req_q) begin
               present_d = size_q != 17'd0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         if (!fifo_full || pop) begin
            fifo_d[wr_ptr_q[PW-1:0]] = push_entry;
            wr_ptr_d                 = wr_ptr_q + PTR_ONE;
         end else begin
            ovf_d = 1'b1;
         end
      end

      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_be_d   = mem_be_q;
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         mem_req_d  = 1'b1;
         mem_addr_d = BASE_ADDR + {7'd0, head.w, 1'b0};
         mem_din_d  = head.data;
         mem_be_d   = head.be;
      end else if (mem_req_q && mem.mem_ack) begin
         mem_req_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         cart_dl_q  <= 1'b0;
         held_vld_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_be_q   <= '0;
         present_q  <= 1'b0;
         size_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cart_dl_q  <= cart_dl;
         held_vld_q <= held_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_be_q   <= mem_be_d;
         present_q  <= present_d;
         size_q     <= size_d;
         ovf_q      <= ovf_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      held_byte_q <= held_byte_d;
      held_w_q    <= held_w_d;
      fifo_q      <= fifo_d;
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;
   assign mem.mem_din  = mem_din_q;
   assign mem.mem_be   = mem_be_q;
   assign cart_present = present_q;
   assign cart_size    = size_q;
   assign busy         = state_q != IDLE;
   assign overflow     = ovf_q;
endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: table of whole downloads plus hand-written
// sequences for FIFO overflow, eject and reset during a pending write.
module tb_cart_loader;
   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        eject;
   logic        cart_present;
   logic [16:0] cart_size;
   logic        busy;
   logic        overflow;

   cart_loader_if mem_if ();

   cart_loader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .eject          (eject),
      .mem            (mem_if),
      .cart_present   (cart_present),
      .cart_size      (cart_size),
      .busy           (busy),
      .overflow       (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // SDRAM responder: logs each new request, checks the bus holds still, acks after ack_dly.
   logic [23:0] log_addr [$];
   logic [15:0] log_din  [$];
   logic [1:0]  log_be   [$];
   logic [23:0] cur_addr;
   logic [15:0] cur_din;
   logic [1:0]  cur_be;
   logic        seen = 1'b0;
   int          cnt = 0;
   int          ack_dly = 2;

   always @(negedge clk_sys) begin
      mem_if.mem_ack = 1'b0;
      if (mem_if.mem_req === 1'b1) begin
         if (!seen) begin
            seen     = 1'b1;
            cur_addr = mem_if.mem_addr;
            cur_din  = mem_if.mem_din;
            cur_be   = mem_if.mem_be;
            log_addr.push_back(cur_addr);
            log_din.push_back(cur_din);
            log_be.push_back(cur_be);
            cnt = ack_dly;
         end else begin
            check("stable_addr", 32'(mem_if.mem_addr), 32'(cur_addr));
            check("stable_data", 32'({mem_if.mem_din, mem_if.mem_be}), 32'({cur_din, cur_be}));
         end
         if (cnt == 0) begin
            mem_if.mem_ack = 1'b1;
            seen = 1'b0;
         end else begin
            cnt--;
         end
      end else begin
         seen = 1'b0;
      end
   end

   task automatic run_dl(input logic [7:0] idx, input logic [24:0] a0, input int n,
                         input logic [7:0] base, input logic [7:0] step, input int gap,
                         output logic busy_seen);
      logic [7:0] v;
      v = base;
      busy_seen = 1'b0;
      @(negedge clk_sys);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      for (int i = 0; i < n; i++) begin
         ioctl_wr   = 1'b1;
         ioctl_addr = a0 + 25'(i);
         ioctl_dout = v;
         v = v + step;
         @(negedge clk_sys);
         ioctl_wr = 1'b0;
         if (i == 0) busy_seen = busy;
         repeat (gap - 1) @(negedge clk_sys);
      end
      ioctl_download = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy || mem_if.mem_req) && k < 1000) begin
         @(negedge clk_sys);
         k++;
      end
      check("idle_in_time", 32'(k < 1000), 32'd1);
      repeat (2) @(negedge clk_sys);
   endtask

   typedef struct {
      logic [7:0]  idx;
      logic [24:0] a0;
      int          nbytes;
      logic [7:0]  base;
      logic [7:0]  step;
      int          gap;
      int          ackd;
      logic        busy_mid;
      int          nwr;
      logic [23:0] f_addr;
      logic [15:0] f_din;
      logic [1:0]  f_be;
      logic [23:0] l_addr;
      logic [15:0] l_din;
      logic [1:0]  l_be;
      logic [16:0] size;
      logic        ovf;
      logic        present;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   nstart, nwr, k, nb;
      logic bm;
      logic [15:0] w;

      //        idx    a0         n   base   step   gap ack busy nwr  first                   last                    size  ovf pres
      vecs[0] = '{8'h01, 25'd0,     4, 8'h11, 8'h11, 4, 2, 1'b1, 2, 24'h040000, 16'h2211, 2'b11, 24'h040002, 16'h4433, 2'b11, 17'd4, 1'b0, 1'b1};
      vecs[1] = '{8'h01, 25'd0,     3, 8'hAA, 8'h11, 4, 2, 1'b1, 2, 24'h040000, 16'hBBAA, 2'b11, 24'h040002, 16'h00CC, 2'b01, 17'd3, 1'b0, 1'b1};
      vecs[2] = '{8'h00, 25'd0,     8, 8'h55, 8'h01, 2, 2, 1'b0, 0, 24'h0,      16'h0,    2'b00, 24'h0,      16'h0,    2'b00, 17'd3, 1'b0, 1'b1};
      vecs[3] = '{8'h01, 25'h10000, 1, 8'h77, 8'h01, 4, 2, 1'b1, 0, 24'h0,      16'h0,    2'b00, 24'h0,      16'h0,    2'b00, 17'd0, 1'b1, 1'b0};
      vecs[4] = '{8'h03, 25'd1,     1, 8'h5A, 8'h01, 4, 2, 1'b1, 1, 24'h040000, 16'h5A00, 2'b10, 24'h040000, 16'h5A00, 2'b10, 17'd2, 1'b0, 1'b1};
      vecs[5] = '{8'h02, 25'd0,     2, 8'h66, 8'h01, 3, 2, 1'b0, 0, 24'h0,      16'h0,    2'b00, 24'h0,      16'h0,    2'b00, 17'd2, 1'b0, 1'b1};

      reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = 8'h00; eject = 1'b0; mem_if.mem_ack = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("rst_mem_req",  32'(mem_if.mem_req),  32'd0);
      check("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
      check("rst_mem_din",  32'(mem_if.mem_din),  32'd0);
      check("rst_mem_be",   32'(mem_if.mem_be),   32'd0);
      check("rst_present",  32'(cart_present),    32'd0);
      check("rst_size",     32'(cart_size),       32'd0);
      check("rst_busy",     32'(busy),            32'd0);
      check("rst_overflow", 32'(overflow),        32'd0);
      reset = 1'b0;
      @(negedge clk_sys);

      for (int v = 0; v < 6; v++) begin
         ack_dly = vecs[v].ackd;
         nstart  = log_addr.size();
         run_dl(vecs[v].idx, vecs[v].a0, vecs[v].nbytes, vecs[v].base, vecs[v].step, vecs[v].gap, bm);
         wait_idle();
         nwr = log_addr.size() - nstart;
         check($sformatf("v%0d_busy_mid", v), 32'(bm), 32'(vecs[v].busy_mid));
         check($sformatf("v%0d_nwrites", v), 32'(nwr), 32'(vecs[v].nwr));
         if (vecs[v].nwr > 0 && nwr > 0) begin
            check($sformatf("v%0d_first_addr", v), 32'(log_addr[nstart]), 32'(vecs[v].f_addr));
            check($sformatf("v%0d_first_din", v),  32'(log_din[nstart]),  32'(vecs[v].f_din));
            check($sformatf("v%0d_first_be", v),   32'(log_be[nstart]),   32'(vecs[v].f_be));
            check($sformatf("v%0d_last_addr", v),  32'(log_addr[nstart+nwr-1]), 32'(vecs[v].l_addr));
            check($sformatf("v%0d_last_din", v),   32'(log_din[nstart+nwr-1]),  32'(vecs[v].l_din));
            check($sformatf("v%0d_last_be", v),    32'(log_be[nstart+nwr-1]),   32'(vecs[v].l_be));
         end
         check($sformatf("v%0d_size", v),     32'(cart_size),    32'(vecs[v].size));
         check($sformatf("v%0d_overflow", v), 32'(overflow),     32'(vecs[v].ovf));
         check($sformatf("v%0d_present", v),  32'(cart_present), 32'(vecs[v].present));
         check($sformatf("v%0d_busy_end", v), 32'(busy),         32'd0);
      end

      // Burst: 20 bytes (value == address) every cycle with slow acks.
      ack_dly = 10;
      nstart  = log_addr.size();
      run_dl(8'h01, 25'd0, 20, 8'h00, 8'h01, 1, bm);
      wait_idle();
      nb = log_addr.size() - nstart;
      check("burst_overflow", 32'(overflow), 32'd1);
      check("burst_size", 32'(cart_size), 32'd20);
      check("burst_present", 32'(cart_present), 32'd1);
      check("burst_some_writes", 32'(nb > 0 && nb < 10), 32'd1);
      if (nb > 0) check("burst_first_addr", 32'(log_addr[nstart]), 32'h040000);
      for (int i = nstart; i < nstart + nb; i++) begin
         w = 16'((log_addr[i] - 24'h040000) >> 1);
         check("burst_addr_range", 32'(log_addr[i] <= 24'h040012), 32'd1);
         check("burst_din", 32'(log_din[i]), 32'({w[6:0], 1'b1, w[6:0], 1'b0}));
         check("burst_be", 32'(log_be[i]), 32'd3);
         if (i > nstart) check("burst_addr_order", 32'(log_addr[i] > log_addr[i-1]), 32'd1);
      end

      // Eject in IDLE clears presence but keeps the size.
      @(negedge clk_sys);
      eject = 1'b1;
      @(negedge clk_sys);
      eject = 1'b0;
      check("eject_present", 32'(cart_present), 32'd0);
      check("eject_size", 32'(cart_size), 32'd20);

      // Reset while a write is pending, then a clean 2-byte load.
      ack_dly = 50;
      run_dl(8'h01, 25'd0, 4, 8'h10, 8'h10, 4, bm);
      k = 0;
      while (mem_if.mem_req !== 1'b1 && k < 100) begin
         @(negedge clk_sys);
         k++;
      end
      check("pend_req_seen", 32'(mem_if.mem_req), 32'd1);
      reset = 1'b1;
      @(negedge clk_sys);
      check("midrst_mem_req", 32'(mem_if.mem_req), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
      check("midrst_size", 32'(cart_size), 32'd0);
      reset   = 1'b0;
      ack_dly = 2;
      nstart  = log_addr.size();
      repeat (10) @(negedge clk_sys);
      check("midrst_fifo_empty", 32'(log_addr.size() - nstart), 32'd0);
      run_dl(8'h01, 25'd0, 2, 8'hC3, 8'h11, 3, bm);
      wait_idle();
      nwr = log_addr.size() - nstart;
      check("post_nwrites", 32'(nwr), 32'd1);
      if (nwr > 0) begin
         check("post_addr", 32'(log_addr[nstart]), 32'h040000);
         check("post_din", 32'(log_din[nstart]), 32'hD4C3);
         check("post_be", 32'(log_be[nstart]), 32'd3);
      end
      check("post_size", 32'(cart_size), 32'd2);
      check("post_present", 32'(cart_present), 32'd1);
      check("post_overflow", 32'(overflow), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Sits between the data_io download stream and the SDRAM write port used by the MO core.
- Captures cartridge image bytes (ROM/M5 downloads) and packs them into 16-bit words.
- Buffers the words in a small FIFO and writes them into the cartridge region of SDRAM using a req/ack handshake.
- Also owns the cartridge_present / size bookkeeping, including eject.

Parameters:
- BASE_ADDR, 24'h040000: SDRAM byte address of cartridge byte 0 (bit 0 must be 0).
- MAX_BYTES, 65536: largest accepted image; bytes at ioctl_addr >= MAX_BYTES are dropped.
- FIFO_DEPTH, 4: word FIFO entries (power of two, >= 2).
- CART_BIT, 0: ioctl_index bit that marks a cartridge download.

Ports:
- clk_sys  in  1  system clock (32 MHz)
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  download active
- ioctl_index  in  8  download slot
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte address within image
- ioctl_dout  in  8  byte data
- eject  in  1  level; eject cartridge (status bit)
- mem_req  out  1  write request
- mem_addr  out  24  SDRAM byte address, bit 0 = 0
- mem_din  out  16  write data {high byte, low byte}
- mem_be  out  2  byte enables; bit 1 = high byte
- mem_ack  in  1  one-cycle write complete
- cart_present  out  1  valid cartridge in SDRAM
- cart_size  out  17  bytes accepted (highest accepted address + 1)
- busy  out  1  loading or draining
- overflow  out  1  sticky; data was dropped

Behaviour:
- Reset: clk_sys, synchronous active-high. All outputs are 0 at reset: mem_req, mem_addr, mem_din, mem_be, cart_present, cart_size, busy, overflow. FIFO is emptied, the held byte is invalidated, and the FSM goes to IDLE. A reset mid-transfer drops mem_req in the same cycle, and the pending write is abandoned.
- Active download (cart_dl): ioctl_download & ioctl_index[CART_BIT]. Non-cartridge downloads are ignored entirely.
- FSM states:
  - IDLE: on a rising edge of cart_dl, clear cart_present, cart_size and overflow, invalidate the held byte, go to LOAD.
  - LOAD: accept bytes. On cart_dl falling, flush the held byte if valid, then go to DRAIN.
  - DRAIN: when the FIFO is empty and no request is outstanding: set cart_present = (cart_size != 0), go to IDLE.
- busy = state != IDLE.
- Byte packing in LOAD, on ioctl_wr with ioctl_addr < MAX_BYTES. Let w = ioctl_addr[16:1].
  - addr[0]=0, no held byte: hold the byte and w. No push.
  - addr[0]=0, held byte present: push the held byte as {8'h00, held}, be=01, then hold the new byte.
  - addr[0]=1, held byte with the same w: push {dout, held}, be=11, invalidate the held byte.
  - addr[0]=1, held byte with a different w: push the held byte as be=01 and drop the new byte. Set overflow. (Non-sequential high byte; data_io is always sequential, so this is an error path.)
  - addr[0]=1, no held byte: push {dout, 8'h00}, be=10.
  - Every accepted byte updates cart_size = max(cart_size, addr+1).
  - Bytes with addr >= MAX_BYTES: dropped, overflow set, cart_size unchanged.
- At most one FIFO push per cycle. FIFO entry = {w, data16, be}.
- FIFO:
  - Push accepted when not full, or when a pop occurs in the same cycle.
  - Push attempted while full without a pop: word dropped, overflow set.
  - The ioctl stream has no backpressure, so the SDRAM side must average one write per 2 ioctl_wr.
- Memory handshake:
  - When mem_req=0 and the FIFO is non-empty: pop, drive mem_addr = BASE_ADDR + {w,1'b0}, mem_din, mem_be, and set mem_req=1 on the next edge.
  - Hold all mem_* outputs stable until the mem_ack cycle; mem_req falls on the following edge.
  - The earliest next mem_req is one cycle after mem_req falls (one idle cycle between requests).
  - mem_ack while mem_req=0 is ignored.
- Eject:
  - When eject=1 and state=IDLE: clear cart_present (cart_size is kept).
  - Ignored while busy.
  - A new cart_dl rising edge has priority over eject in the same cycle.
- overflow clears only on reset or at the start of a new cartridge download.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 at addr 0..3 (ioctl_wr every 4 cycles), then download ends, mem_ack 2 cycles after each req → writes (0x040000, 0x2211, be=11) and (0x040002, 0x4433, be=11); cart_size=4; cart_present=1 after last ack; busy=0; overflow=0.
- Odd-length image of 3 bytes 0xAA,0xBB,0xCC → second write is addr 0x040002, din 0x00CC, be=01, issued after download falls; cart_size=3.
- Back-to-back ioctl_wr every cycle for 20 bytes, mem_ack delayed 10 cycles → FIFO fills, overflow=1, no write issued with an address beyond 0x040012; mem_* stable during each req.
- Byte at ioctl_addr=65536 with MAX_BYTES=65536 → no write, overflow=1, cart_size unchanged.
- Download of ioctl_index=0 with 8 bytes → no mem_req; cart_present, cart_size and busy unchanged.
- After a load: eject=1 → cart_present=0 next cycle. Reset asserted while mem_req=1 → mem_req=0 next cycle, FIFO empty, state IDLE; a later 2-byte download completes normally.
